// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared opcodes, response codes, states and per-opcode sizes
// Purpose: constants and the FSM encoding used by the debug host controller.
// Ports: none (package).
package dbg_pkg;

  localparam logic [7:0] OP_WRI   = 8'h01;
  localparam logic [7:0] OP_WRD   = 8'h02;
  localparam logic [7:0] OP_RDI   = 8'h03;
  localparam logic [7:0] OP_RDD   = 8'h04;
  localparam logic [7:0] OP_START = 8'h05;
  localparam logic [7:0] OP_QUIT  = 8'h06;
  localparam logic [7:0] OP_RDPC  = 8'h07;

  localparam logic [7:0] RSP_ACK = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  // argument bytes following the opcode
  localparam logic [2:0] ARGS_WR    = 3'd6;
  localparam logic [2:0] ARGS_RD    = 3'd2;
  localparam logic [2:0] ARGS_START = 3'd4;
  localparam logic [2:0] ARGS_NONE  = 3'd0;

  // response lengths in bytes
  localparam logic [2:0] LEN_ACK  = 3'd1;
  localparam logic [2:0] LEN_WORD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_EXEC,
    S_RDWAIT,
    S_RESP
  } state_t;

  // unknown opcodes take no arguments and are rejected in EXEC
  function automatic logic [2:0] op_args(input logic [7:0] op);
    case (op)
      OP_WRI, OP_WRD: return ARGS_WR;
      OP_RDI, OP_RDD: return ARGS_RD;
      OP_START:       return ARGS_START;
      default:        return ARGS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dbg_host_ctrl_if.sv
// rtl/dbg_host_ctrl_if.sv - host-side command/response byte streams
// Purpose: groups the command byte stream (host -> controller) and the
// response byte stream (controller -> host).
// Modports: master = host link side, slave = controller side.
interface dbg_host_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/dbg_rsp_ser.sv
// rtl/dbg_rsp_ser.sv - little-endian response byte serializer
// Purpose: loaded with a word and a length (1 or 4), emits bytes LSB first
// over a valid/ready handshake; done marks the last byte being taken.
// Ports: clk, rst (async high), load/load_word/load_len in,
// rsp_valid/rsp_data out, rsp_ready in, done out.
module dbg_rsp_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic [2:0]  load_len,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  input  logic        rsp_ready,
  output logic        done
);

  logic [31:0] word;
  logic [2:0]  rem;
  logic        valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word    <= '0;
      rem     <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word    <= load_word;
      rem     <= load_len;
      valid_q <= 1'b1;
    end else if (valid_q && rsp_ready) begin
      rem <= rem - 3'd1;
      if (rem == 3'd1) begin
        valid_q <= 1'b0;
      end else begin
        word <= {8'h00, word[31:8]};
      end
    end
  end

  // data comes straight from the register, so it holds while ready is low
  assign rsp_valid = valid_q;
  assign rsp_data  = word[7:0];
  assign done      = valid_q && rsp_ready && (rem == 3'd1);

endmodule

// File: rtl/dbg_host_ctrl.sv
// rtl/dbg_host_ctrl.sv - debug host controller: command bytes to CPU control/RAM access
// Purpose: parses opcode + LE arguments, performs RAM writes/reads, PC read,
// start/quit, and returns an ack/error byte or a 4-byte LE word.
// Ports: clk, rst (async high); host (cmd/rsp streams, slave modport);
// cpu_start, quit_cmd, start_adr; i/d RAM write and read ports; pc_data; busy.
// Option: DBG_CMD_TIMEOUT_EN aborts a stalled command after TIMEOUT_CYC idle cycles.
module dbg_host_ctrl
  import dbg_pkg::*;
#(
  parameter int RD_LAT      = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  dbg_host_ctrl_if.slave       host,
  output logic                 cpu_start,
  output logic                 quit_cmd,
  output logic [29:0]          start_adr,
  output logic [9:0]           i_ram_wadr,
  output logic [31:0]          i_ram_wdata,
  output logic                 i_ram_wen,
  output logic [9:0]           d_ram_wadr,
  output logic [31:0]          d_ram_wdata,
  output logic                 d_ram_wen,
  output logic [9:0]           i_ram_radr,
  output logic                 i_read_sel,
  input  logic [31:0]          i_ram_rdata,
  output logic [9:0]           d_ram_radr,
  output logic                 d_read_sel,
  input  logic [31:0]          d_ram_rdata,
  input  logic [31:0]          pc_data,
  output logic                 busy
);

  state_t      state, state_nxt;
  logic [7:0]  opcode;
  logic [47:0] sr;
  logic [2:0]  arg_left;
  logic [15:0] rd_cnt;
  logic        alive;
  logic        accept, last_arg, timeout_hit;
  logic [47:0] sr_nxt;
  logic        ser_load, ser_done;
  logic [31:0] ser_word;
  logic [2:0]  ser_len;

  // alive keeps cmd_ready low for the first cycle out of reset
  assign host.cmd_ready = alive && (state == S_IDLE || state == S_ARG);
  assign accept   = host.cmd_valid && host.cmd_ready;
  assign sr_nxt   = {host.cmd_data, sr[47:8]};
  assign last_arg = (state == S_ARG) && accept && (arg_left == 3'd1);
  assign busy     = (state != S_IDLE);

`ifdef DBG_CMD_TIMEOUT_EN
  logic [31:0] idle_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state != S_ARG || accept) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
  // abort at the end of the TIMEOUT_CYC-th cycle without a byte
  assign timeout_hit = (state == S_ARG) && !accept &&
                       (idle_cnt == 32'(TIMEOUT_CYC) - 32'd1);
`else
  assign timeout_hit = 1'b0;
  wire [31:0] unused_timeout = 32'(TIMEOUT_CYC);
`endif

  // sr[7:0] only shifts out; address bits [15:12] and [1:0] are ignored
  wire unused_bits = ^{sr[7:0], sr_nxt[15:12], sr_nxt[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ser_load   = 1'b0;
    ser_word   = {24'h0, RSP_ACK};
    ser_len    = LEN_ACK;
    i_ram_wen  = 1'b0;
    d_ram_wen  = 1'b0;
    quit_cmd   = 1'b0;
    i_read_sel = 1'b0;
    d_read_sel = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (op_args(host.cmd_data) == ARGS_NONE) ? S_EXEC : S_ARG;
        end
      end
      S_ARG: begin
        if (timeout_hit) begin
          ser_load  = 1'b1;
          ser_word  = {24'h0, RSP_ERR};
          state_nxt = S_RESP;
        end else if (last_arg) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = S_RESP;
        ser_load  = 1'b1;
        case (opcode)
          OP_WRI:  i_ram_wen = 1'b1;
          OP_WRD:  d_ram_wen = 1'b1;
          OP_RDI: begin
            i_read_sel = 1'b1;
            ser_load   = 1'b0;
            state_nxt  = S_RDWAIT;
          end
          OP_RDD: begin
            d_read_sel = 1'b1;
            ser_load   = 1'b0;
            state_nxt  = S_RDWAIT;
          end
          OP_START: ;
          OP_QUIT: quit_cmd = 1'b1;
          OP_RDPC: begin
            ser_word = pc_data;
            ser_len  = LEN_WORD;
          end
          default: ser_word = {24'h0, RSP_ERR};
        endcase
      end
      S_RDWAIT: begin
        i_read_sel = (opcode == OP_RDI);
        d_read_sel = (opcode == OP_RDD);
        if (rd_cnt == 16'(RD_LAT)) begin
          ser_load  = 1'b1;
          ser_word  = (opcode == OP_RDI) ? i_ram_rdata : d_ram_rdata;
          ser_len   = LEN_WORD;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (ser_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive       <= 1'b0;
      opcode      <= '0;
      sr          <= '0;
      arg_left    <= '0;
      rd_cnt      <= '0;
      cpu_start   <= 1'b0;
      start_adr   <= '0;
      i_ram_wadr  <= '0;
      i_ram_wdata <= '0;
      d_ram_wadr  <= '0;
      d_ram_wdata <= '0;
      i_ram_radr  <= '0;
      d_ram_radr  <= '0;
    end else begin
      alive     <= 1'b1;
      cpu_start <= (state == S_EXEC) && (opcode == OP_START);
      if (accept) begin
        if (state == S_IDLE) begin
          opcode   <= host.cmd_data;
          arg_left <= op_args(host.cmd_data);
        end else begin
          sr       <= sr_nxt;
          arg_left <= arg_left - 3'd1;
        end
      end
      // addresses/data are loaded with the final byte so they are valid in EXEC
      if (last_arg) begin
        case (opcode)
          OP_WRI: begin
            i_ram_wadr  <= sr_nxt[11:2];
            i_ram_wdata <= sr_nxt[47:16];
          end
          OP_WRD: begin
            d_ram_wadr  <= sr_nxt[11:2];
            d_ram_wdata <= sr_nxt[47:16];
          end
          OP_RDI:  i_ram_radr <= sr_nxt[43:34];
          OP_RDD:  d_ram_radr <= sr_nxt[43:34];
          default: ;
        endcase
      end
      if (state == S_EXEC && opcode == OP_START) begin
        start_adr <= sr[47:18];
      end
      if (state == S_EXEC) begin
        rd_cnt <= 16'd1;
      end else if (state == S_RDWAIT) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

  dbg_rsp_ser u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_word (ser_word),
    .load_len  (ser_len),
    .rsp_valid (host.rsp_valid),
    .rsp_data  (host.rsp_data),
    .rsp_ready (host.rsp_ready),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_dbg_host_ctrl.sv
// tb/tb_dbg_host_ctrl.sv - directed self-checking bench for dbg_host_ctrl
module tb_dbg_host_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_start, quit_cmd, busy;
  logic [29:0] start_adr;
  logic [9:0]  i_ram_wadr, d_ram_wadr, i_ram_radr, d_ram_radr;
  logic [31:0] i_ram_wdata, d_ram_wdata;
  logic        i_ram_wen, d_ram_wen, i_read_sel, d_read_sel;
  logic [31:0] i_ram_rdata = '0;
  logic [31:0] d_ram_rdata = '0;
  logic [31:0] pc_data = '0;

  int vectors = 0;
  int miscompares = 0;

  dbg_host_ctrl_if bus ();

  dbg_host_ctrl #(.RD_LAT(2), .TIMEOUT_CYC(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (bus),
    .cpu_start  (cpu_start),
    .quit_cmd   (quit_cmd),
    .start_adr  (start_adr),
    .i_ram_wadr (i_ram_wadr),
    .i_ram_wdata(i_ram_wdata),
    .i_ram_wen  (i_ram_wen),
    .d_ram_wadr (d_ram_wadr),
    .d_ram_wdata(d_ram_wdata),
    .d_ram_wen  (d_ram_wen),
    .i_ram_radr (i_ram_radr),
    .i_read_sel (i_read_sel),
    .i_ram_rdata(i_ram_rdata),
    .d_ram_radr (d_ram_radr),
    .d_read_sel (d_read_sel),
    .d_ram_rdata(d_ram_rdata),
    .pc_data    (pc_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // all driving and sampling happens 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_accept_wait", 32'(n < 50), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, 32'(n < 50), 32'd1);
    chk(tag, {24'h0, bus.rsp_data}, {24'h0, exp});
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int first_rsp;
    int sel_cnt;
    logic stable;
    logic saw_wen;

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_data",  {24'h0, bus.rsp_data}, 32'h0);
    chk("rst_busy",      {31'h0, busy}, 32'h0);
    chk("rst_strobes",   {28'h0, i_ram_wen, d_ram_wen, cpu_start, quit_cmd}, 32'h0);
    chk("rst_read_sel",  {30'h0, i_read_sel, d_read_sel}, 32'h0);
    chk("rst_start_adr", {2'b0, start_adr}, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);

    // WRI 0x0010 <- 0xDEADBEEF
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    chk("wri_wen",       {31'h0, i_ram_wen}, 32'h1);
    chk("wri_wadr",      {22'h0, i_ram_wadr}, 32'h4);
    chk("wri_wdata",     i_ram_wdata, 32'hDEADBEEF);
    chk("wri_d_wen",     {31'h0, d_ram_wen}, 32'h0);
    chk("wri_busy_exec", {31'h0, busy}, 32'h1);
    chk("wri_ready_exec", {31'h0, bus.cmd_ready}, 32'h0);
    tick();
    chk("wri_wen_drop",  {31'h0, i_ram_wen}, 32'h0);
    get_byte("wri_rsp", 8'hAA);
    chk("wri_idle_busy", {31'h0, busy}, 32'h0);

    // RDD 0x0ffc, rdata 0x12345678: read_sel for RD_LAT+1 cycles, rsp at EXEC+3
    d_ram_rdata = 32'h12345678;
    send_byte(8'h04); send_byte(8'hFC); send_byte(8'h0F);
    chk("rdd_radr", {22'h0, d_ram_radr}, 32'h3FF);
    chk("rdd_i_sel", {31'h0, i_read_sel}, 32'h0);
    first_rsp = -1;
    sel_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (d_read_sel) sel_cnt++;
      if (bus.rsp_valid) begin
        first_rsp = k;
        break;
      end
      tick();
    end
    chk("rdd_sel_cycles", 32'(sel_cnt), 32'd3);
    chk("rdd_rsp_latency", 32'(first_rsp), 32'd3);
    chk("rdd_radr_held", {22'h0, d_ram_radr}, 32'h3FF);
    get_byte("rdd_b0", 8'h78);
    get_byte("rdd_b1", 8'h56);
    get_byte("rdd_b2", 8'h34);
    get_byte("rdd_b3", 8'h12);
    chk("rdd_sel_off", {31'h0, d_read_sel}, 32'h0);

    // RDI 0x1234: bits [15:12] and [1:0] ignored -> radr 0x08D
    i_ram_rdata = 32'hA5A50F0F;
    send_byte(8'h03); send_byte(8'h34); send_byte(8'h12);
    chk("rdi_sel", {31'h0, i_read_sel}, 32'h1);
    chk("rdi_radr", {22'h0, i_ram_radr}, 32'h08D);
    get_byte("rdi_b0", 8'h0F);
    get_byte("rdi_b1", 8'h0F);
    get_byte("rdi_b2", 8'hA5);
    get_byte("rdi_b3", 8'hA5);

    // START 0x00000100 -> start_adr 0x40, pulse the cycle after EXEC
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    chk("start_exec_pulse", {31'h0, cpu_start}, 32'h0);
    tick();
    chk("start_pulse", {31'h0, cpu_start}, 32'h1);
    chk("start_adr", {2'b0, start_adr}, 32'h40);
    tick();
    chk("start_pulse_drop", {31'h0, cpu_start}, 32'h0);
    get_byte("start_rsp", 8'hAA);
    chk("start_adr_held", {2'b0, start_adr}, 32'h40);

    // unknown opcode 0x5A -> 0xEE, no side effects
    send_byte(8'h5A);
    chk("unk_no_strobe", {28'h0, i_ram_wen, d_ram_wen, quit_cmd, cpu_start}, 32'h0);
    get_byte("unk_rsp", 8'hEE);

    // QUIT accepted normally afterwards
    send_byte(8'h06);
    chk("quit_pulse", {31'h0, quit_cmd}, 32'h1);
    tick();
    chk("quit_drop", {31'h0, quit_cmd}, 32'h0);
    get_byte("quit_rsp", 8'hAA);

    // RDPC with rsp_ready held low 10 cycles
    pc_data = 32'hCAFE0004;
    send_byte(8'h07);
    tick();
    tick();
    pc_data = 32'h0;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!bus.rsp_valid || bus.rsp_data !== 8'h04) stable = 1'b0;
      tick();
    end
    chk("rdpc_stall_stable", {31'h0, stable}, 32'h1);
    get_byte("rdpc_b0", 8'h04);
    get_byte("rdpc_b1", 8'h00);
    get_byte("rdpc_b2", 8'hFE);
    get_byte("rdpc_b3", 8'hCA);

    // WRD aborted by reset after 3 argument bytes
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h00); send_byte(8'h11);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    chk("abort_start_adr", {2'b0, start_adr}, 32'h0);
    chk("abort_i_wadr", {22'h0, i_ram_wadr}, 32'h0);
    saw_wen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (d_ram_wen) saw_wen = 1'b1;
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (d_ram_wen) saw_wen = 1'b1;
      tick();
    end
    chk("abort_no_wen", {31'h0, saw_wen}, 32'h0);
    chk("abort_d_wadr", {22'h0, d_ram_wadr}, 32'h0);
    chk("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);

    // a fresh WRD works after the abort
    send_byte(8'h02); send_byte(8'h08); send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hAD); send_byte(8'h0B);
    chk("wrd_wen", {31'h0, d_ram_wen}, 32'h1);
    chk("wrd_wadr", {22'h0, d_ram_wadr}, 32'h2);
    chk("wrd_wdata", d_ram_wdata, 32'h0BADF00D);
    get_byte("wrd_rsp", 8'hAA);

`ifdef DBG_CMD_TIMEOUT_EN
    // stalled WRD after 3 argument bytes times out with 0xEE
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h00); send_byte(8'h11);
    saw_wen = 1'b0;
    for (int k = 0; k < 40 && !bus.rsp_valid; k++) begin
      if (d_ram_wen) saw_wen = 1'b1;
      tick();
    end
    chk("timeout_no_wen", {31'h0, saw_wen}, 32'h0);
    get_byte("timeout_rsp", 8'hEE);
    chk("timeout_idle", {31'h0, busy}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
